// File: rtl/instr_fetch_pkg.sv
// Shared constants for the instruction fetch stage: reset vector, instruction
// size, canonical NOP, and the occupancy helper used by the issue rule.
package instr_fetch_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam int          INSTR_BYTES      = 4;
   localparam logic [31:0] NOP              = 32'h0000_0013;

   // Number of instructions still owned by the fetch stage after this cycle's
   // transfer: held entries plus the request in flight, minus the one decode takes.
   function automatic logic [2:0] occupancy(input logic out_vld,
                                            input logic skid_vld,
                                            input logic req_vld,
                                            input logic fire);
      return {2'b00, out_vld} + {2'b00, skid_vld} + {2'b00, req_vld} - {2'b00, fire};
   endfunction

endpackage

// File: rtl/instr_fetch_skid_buf.sv
// Output register plus one-entry skid for fetched instructions.
// Handshake: a transfer happens in every cycle where out_vld && out_ready; the
// producer side (in_vld) has no ready because the fetch issue rule guarantees
// at most one arrival can be pending beyond the output entry.
// While out_vld && !out_ready, out_inst/out_pc stay stable.
module instr_fetch_skid_buf
   import instr_fetch_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_vld,
   input  logic [DATA_WIDTH-1:0] in_inst,
   input  logic [ADDR_WIDTH-1:0] in_pc,
   input  logic                  out_ready,
   output logic                  out_vld,
   output logic [DATA_WIDTH-1:0] out_inst,
   output logic [ADDR_WIDTH-1:0] out_pc,
   output logic                  skid_vld
);

   logic [DATA_WIDTH-1:0] skid_inst;
   logic [ADDR_WIDTH-1:0] skid_pc;
   logic                  fire;
   logic                  direct_load;

   // Arrivals go straight to the output entry when it is free after this cycle
   // and nothing older waits in the skid; otherwise they park in the skid.
   always_comb begin
      fire        = out_vld && out_ready;
      direct_load = !out_vld || (fire && !skid_vld);
   end

   // Output/skid entries; flush drops both valids but keeps the last data visible.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_vld   <= 1'b0;
         out_inst  <= '0;
         out_pc    <= '0;
         skid_vld  <= 1'b0;
         skid_inst <= '0;
         skid_pc   <= '0;
      end else if (flush) begin
         out_vld  <= 1'b0;
         skid_vld <= 1'b0;
      end else if (direct_load) begin
         out_vld <= in_vld;
         if (in_vld) begin
            out_inst <= in_inst;
            out_pc   <= in_pc;
         end
      end else if (fire) begin
         // Skid holds the older instruction: promote it, refill skid from arrival.
         out_vld  <= 1'b1;
         out_inst <= skid_inst;
         out_pc   <= skid_pc;
         skid_vld <= in_vld;
         if (in_vld) begin
            skid_inst <= in_inst;
            skid_pc   <= in_pc;
         end
      end else if (in_vld) begin
         skid_vld  <= 1'b1;
         skid_inst <= in_inst;
         skid_pc   <= in_pc;
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, drives the registered-read instruction
// RAM port, tracks the single request in flight, and handles redirects.
// Decode handshake: inst is transferred in each cycle with inst_valid && inst_ready.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEFAULT)
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  inst_valid,
   input  logic                  inst_ready,
   output logic [DATA_WIDTH-1:0] inst,
   output logic [ADDR_WIDTH-1:0] inst_pc
);

   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);
   localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(INSTR_BYTES);

   logic [ADDR_WIDTH-1:0] pc_q;
   logic                  req_vld;
   logic [ADDR_WIDTH-1:0] req_pc;
   logic                  skid_vld;
   logic                  fire;
   logic [2:0]            cnt;
   logic                  issue;

   // Issue only when the response is guaranteed a slot (output or skid).
   always_comb begin
      fire  = inst_valid && inst_ready;
      cnt   = occupancy(inst_valid, skid_vld, req_vld, fire);
      issue = (cnt < 3'd2) && !redirect_valid;
   end

   // PC and in-flight request tracking; redirect overrides issue and kills the request.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q    <= RESET_PC;
         req_vld <= 1'b0;
         req_pc  <= '0;
      end else if (redirect_valid) begin
         pc_q    <= redirect_pc & ALIGN_MASK;
         req_vld <= 1'b0;
      end else if (issue) begin
         pc_q    <= pc_q + PC_STEP;
         req_vld <= 1'b1;
         req_pc  <= pc_q;
      end else begin
         req_vld <= 1'b0;
      end
   end

   assign imem_addr = pc_q;

   instr_fetch_skid_buf #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect_valid),
      .in_vld    (req_vld),
      .in_inst   (imem_rdata),
      .in_pc     (req_pc),
      .out_ready (inst_ready),
      .out_vld   (inst_valid),
      .out_inst  (inst),
      .out_pc    (inst_pc),
      .skid_vld  (skid_vld)
   );

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: RAM model, directed scenarios, randomized traffic,
// and a scoreboard of expected program-order PCs checked on every transfer.
module tb_instr_fetch;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam int          STREAM = 256;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = '0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [31:0] inst;
   logic [31:0] inst_pc;

   int checks     = 0;
   int failures   = 0;
   int deliveries = 0;

   logic [31:0] exp_q[$];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   instr_fetch u_dut (
      .clk            (clk),
      .rst            (rst),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst           (inst),
      .inst_pc        (inst_pc)
   );

   // Instruction image: RAM[0..3] = 13,93,113,193 and distinct words elsewhere.
   function automatic logic [31:0] ram_word(input logic [31:0] a);
      return ((a << 5) + 32'h13) ^ {a[31:27], 27'b0};
   endfunction

   // Registered-read RAM port A.
   always @(posedge clk) imem_rdata <= ram_word(imem_addr);

   task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Program order from a start address: consecutive words, wrapping mod 2^32.
   task automatic load_stream(input logic [31:0] start);
      exp_q.delete();
      for (int i = 0; i < STREAM; i++) exp_q.push_back(start + 32'(4 * i));
   endtask

   // ---------------- monitor / scoreboard ----------------
   int          since = 10;
   logic        prev_stall = 1'b0, prev2_stall = 1'b0, prev_rst = 1'b0;
   logic [31:0] prev_inst = '0, prev_pc = '0, prev_addr = '0;

   always @(negedge clk) begin
      logic        stall_now;
      logic [31:0] e;
      since = (since < 10) ? since + 1 : since;
      if (prev_rst) begin
         chk(!inst_valid, "rst_valid", {31'b0, inst_valid}, 32'h0);
         chk(inst == 32'h0, "rst_inst", inst, 32'h0);
         chk(inst_pc == 32'h0, "rst_inst_pc", inst_pc, 32'h0);
         chk(imem_addr == RST_PC, "rst_addr", imem_addr, RST_PC);
      end
      if (!rst) begin
         if (since == 1 || since == 2)
            chk(!inst_valid, "restart_bubble", {31'b0, inst_valid}, 32'h0);
         else if (since >= 3)
            chk(inst_valid, "no_gap", {31'b0, inst_valid}, 32'h1);
         chk(imem_addr[1:0] == 2'b00, "addr_align", imem_addr, imem_addr & ~32'h3);
         if (prev_stall) begin
            chk(inst == prev_inst, "stall_inst", inst, prev_inst);
            chk(inst_pc == prev_pc, "stall_pc", inst_pc, prev_pc);
         end
         if (prev_stall && prev2_stall)
            chk(imem_addr == prev_addr, "stall_addr", imem_addr, prev_addr);
         if (inst_valid && inst_ready) begin
            deliveries++;
            if (exp_q.size() == 0) begin
               chk(1'b0, "unexpected_inst", inst_pc, 32'hx);
            end else begin
               e = exp_q.pop_front();
               chk(inst_pc == e, "order_pc", inst_pc, e);
               chk(inst == ram_word(e), "inst_data", inst, ram_word(e));
            end
         end
      end
      stall_now   = inst_valid && !inst_ready && !rst && !redirect_valid;
      prev2_stall = prev_stall;
      prev_stall  = stall_now;
      prev_rst    = rst;
      prev_inst   = inst;
      prev_pc     = inst_pc;
      prev_addr   = imem_addr;
      if (rst) begin
         load_stream(RST_PC);
         since = 0;
      end else if (redirect_valid) begin
         load_stream(redirect_pc & ~32'h3);
         since = 0;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_pulse(input int n);
      rst = 1'b1;
      repeat (n) step();
      rst = 1'b0;
   endtask

   task automatic redirect(input logic [31:0] target);
      redirect_valid = 1'b1;
      redirect_pc    = target;
      step();
      redirect_valid = 1'b0;
   endtask

   // Advance until the given pc is presented; inputs may then be set for that cycle.
   task automatic wait_pc(input logic [31:0] target);
      bit found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (inst_valid && inst_pc == target) found = 1'b1;
         else step();
      end
      chk(found, "wait_pc", inst_pc, target);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int gap;
      // 1: reset and full-rate fetch from RESET_PC.
      inst_ready = 1'b1;
      #1;
      reset_pulse(3);
      repeat (8) step();

      // 2: stall at pc 8 for 3 cycles, then release.
      reset_pulse(1);
      wait_pc(32'h8);
      inst_ready = 1'b0;
      repeat (3) step();
      inst_ready = 1'b1;
      repeat (6) step();

      // 3: fill output and skid, then redirect to 0x40 while stalled.
      inst_ready = 1'b0;
      repeat (3) step();
      redirect(32'h40);
      inst_ready = 1'b1;
      repeat (8) step();

      // 4: redirect in the same cycle pc 4 is accepted.
      reset_pulse(1);
      wait_pc(32'h4);
      redirect(32'h100);
      repeat (6) step();

      // 5: misaligned target near the top of the address space.
      redirect(32'hFFFF_FFFE);
      repeat (8) step();

      // 6: reset during a stall with a request in flight.
      inst_ready = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      inst_ready = 1'b1;
      repeat (6) step();

      // Randomized traffic: ready jitter, redirects, rare resets.
      gap = 0;
      for (int c = 0; c < 2500; c++) begin
         inst_ready     = ($urandom_range(0, 3) != 0);
         redirect_valid = 1'b0;
         rst            = 1'b0;
         gap++;
         if ($urandom_range(0, 299) == 0) begin
            rst = 1'b1;
            gap = 0;
         end else if (gap > 150 || $urandom_range(0, 29) == 0) begin
            redirect_valid = 1'b1;
            redirect_pc    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                         : $urandom;
            gap = 0;
         end
         step();
      end
      redirect_valid = 1'b0;
      rst            = 1'b0;
      inst_ready     = 1'b1;
      repeat (6) step();

      chk(deliveries >= 500, "deliveries", 32'(deliveries), 32'd500);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
